reg_file: RTL and testbench

//   General-purpose register file for the single-cycle MIPS CPU datapath.
//   32 x 32-bit registers, two asynchronous read ports (rs/rt operands) and one

---
 rtl/cpu_pkg.sv | 11 +
 rtl/reg_file.sv | 53 +++++
 tb/tb_reg_file.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: register width, register-number width and
// the index of the hardwired zero register.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_file.sv
// 32 x 32-bit MIPS general-purpose register file: two combinational read
// ports, one synchronous write port, register 0 hardwired to zero.
module reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic [ADDR_W-1:0] rna,
  input  logic [ADDR_W-1:0] rnb,
  input  logic [DATA_W-1:0] d,
  input  logic [ADDR_W-1:0] wn,
  input  logic              we,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;

  // One-hot write select; entry 0 is never selected so writes to r0 vanish.
  assign wr_sel[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = we && (wn == ADDR_W'(gi));
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_sel[i]) begin
        regs_d[i] = d;
      end
    end
  end

  // Reset has priority over a write on the same edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (clrn) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read muxes force r0 to zero so it is defined even before the first reset.
  assign qa = (rna == REG_ZERO) ? '0 : regs_q[rna];
  assign qb = (rnb == REG_ZERO) ? '0 : regs_q[rnb];

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, writes, r0 behaviour,
// read-during-write, full sweep and reset priority.
module tb_reg_file;

  logic        clk;
  logic        clrn;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [31:0] d;
  logic [4:0]  wn;
  logic        we;
  logic [31:0] qa;
  logic [31:0] qb;

  int errors = 0;
  int checks = 0;

  reg_file dut (
    .clk  (clk),
    .clrn (clrn),
    .rna  (rna),
    .rnb  (rnb),
    .d    (d),
    .wn   (wn),
    .we   (we),
    .qa   (qa),
    .qb   (qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b1;
    we   = 1'b0;
    tick();
    clrn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rna = 5'(i);
      rnb = 5'(31 - i);
      #1;
      checks++;
      if (qa !== 32'h0) begin
        errors++;
        $display("FAIL reset_qa r%0d: got %h expected %h", i, qa, 32'h0);
      end
      checks++;
      if (qb !== 32'h0) begin
        errors++;
        $display("FAIL reset_qb r%0d: got %h expected %h", 31 - i, qb, 32'h0);
      end
    end
    $display("test_reset: swept 32 addresses on both ports");
  endtask

  task automatic test_write_basic();
    we = 1'b1; wn = 5'd1; d = 32'h0000_000F;
    tick();
    we = 1'b0;
    rna = 5'd0; rnb = 5'd1;
    #1;
    checks++;
    if (qa !== 32'h0) begin
      errors++;
      $display("FAIL write_basic_qa: got %h expected %h", qa, 32'h0);
    end
    checks++;
    if (qb !== 32'h0000_000F) begin
      errors++;
      $display("FAIL write_basic_qb: got %h expected %h", qb, 32'h0000_000F);
    end
    $display("test_write_basic: r1 <= 0000000f, qa=%h qb=%h", qa, qb);
  endtask

  task automatic test_write_zero();
    we = 1'b1; wn = 5'd0; d = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    rna = 5'd0; rnb = 5'd1;
    #1;
    checks++;
    if (qa !== 32'h0) begin
      errors++;
      $display("FAIL write_zero_r0: got %h expected %h", qa, 32'h0);
    end
    checks++;
    if (qb !== 32'h0000_000F) begin
      errors++;
      $display("FAIL write_zero_r1_kept: got %h expected %h", qb, 32'h0000_000F);
    end
    $display("test_write_zero: r0 write discarded, qa=%h", qa);
  endtask

  task automatic test_read_during_write();
    we = 1'b1; wn = 5'd5; d = 32'hA5A5_A5A5;
    rna = 5'd5; rnb = 5'd5;
    #1;
    checks++;
    if (qa !== 32'h0) begin
      errors++;
      $display("FAIL rdw_old_value: got %h expected %h", qa, 32'h0);
    end
    tick();
    checks++;
    if (qa !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL rdw_new_value: got %h expected %h", qa, 32'hA5A5_A5A5);
    end
    we = 1'b0; d = 32'h0000_1234;
    tick();
    checks++;
    if (qb !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL rdw_we0_hold: got %h expected %h", qb, 32'hA5A5_A5A5);
    end
    $display("test_read_during_write: r5 old=0 new=a5a5a5a5 held with we=0");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    logic [4:0]  addrs [3];
    vals[0] = 32'h0000_0001; addrs[0] = 5'd2;
    vals[1] = 32'h0000_0002; addrs[1] = 5'd2;
    vals[2] = 32'h8000_0003; addrs[2] = 5'd3;
    for (int k = 0; k < 3; k++) begin
      we = 1'b1; wn = addrs[k]; d = vals[k];
      rna = addrs[k];
      tick();
      checks++;
      if (qa !== vals[k]) begin
        errors++;
        $display("FAIL back_to_back_%0d r%0d: got %h expected %h", k, addrs[k], qa, vals[k]);
      end
      $display("test_back_to_back: r%0d <= %h read %h", addrs[k], vals[k], qa);
    end
    we = 1'b0;
    rna = 5'd2; rnb = 5'd3;
    #1;
    checks++;
    if (qa !== 32'h0000_0002) begin
      errors++;
      $display("FAIL back_to_back_r2_final: got %h expected %h", qa, 32'h0000_0002);
    end
    checks++;
    if (qb !== 32'h8000_0003) begin
      errors++;
      $display("FAIL back_to_back_r3_final: got %h expected %h", qb, 32'h8000_0003);
    end
  endtask

  task automatic test_all_regs();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    int          j;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wn = 5'(i); d = 32'(i) * 32'h0101_0101;
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      j = (i * 7 + 3) % 32;
      rna = 5'(i);
      rnb = 5'(j);
      exp_a = (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101;
      exp_b = (j == 0) ? 32'h0 : 32'(j) * 32'h0101_0101;
      #1;
      checks++;
      if (qa !== exp_a) begin
        errors++;
        $display("FAIL all_regs_qa r%0d: got %h expected %h", i, qa, exp_a);
      end
      checks++;
      if (qb !== exp_b) begin
        errors++;
        $display("FAIL all_regs_qb r%0d: got %h expected %h", j, qb, exp_b);
      end
    end
    rna = 5'd31; rnb = 5'd31;
    #1;
    checks++;
    if (qa !== 32'h1F1F_1F1F) begin
      errors++;
      $display("FAIL all_regs_r31_qa: got %h expected %h", qa, 32'h1F1F_1F1F);
    end
    checks++;
    if (qb !== 32'h1F1F_1F1F) begin
      errors++;
      $display("FAIL all_regs_r31_qb: got %h expected %h", qb, 32'h1F1F_1F1F);
    end
    $display("test_all_regs: wrote r1..r31, r31 reads qa=%h qb=%h", qa, qb);
  endtask

  task automatic test_reset_priority();
    we = 1'b1; wn = 5'd1; d = 32'h0000_000F;
    tick();
    rnb = 5'd1;
    #1;
    checks++;
    if (qb !== 32'h0000_000F) begin
      errors++;
      $display("FAIL reset_prio_setup: got %h expected %h", qb, 32'h0000_000F);
    end
    clrn = 1'b1; we = 1'b1; wn = 5'd1; d = 32'h0000_0007;
    tick();
    clrn = 1'b0; we = 1'b0;
    checks++;
    if (qb !== 32'h0) begin
      errors++;
      $display("FAIL reset_prio_r1: got %h expected %h", qb, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      rna = 5'(i);
      #1;
      checks++;
      if (qa !== 32'h0) begin
        errors++;
        $display("FAIL reset_prio_sweep r%0d: got %h expected %h", i, qa, 32'h0);
      end
    end
    $display("test_reset_priority: reset with write on r1, qb=%h", qb);
  endtask

  initial begin
    clrn = 1'b1;
    we   = 1'b0;
    wn   = 5'd0;
    d    = 32'h0;
    rna  = 5'd0;
    rnb  = 5'd0;
    test_reset();
    test_write_basic();
    test_write_zero();
    test_read_during_write();
    test_back_to_back();
    test_all_regs();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
